// File: rtl/memory_dumper_pkg.sv
// Shared CPU package: default datapath widths and the memory dumper state encoding.
// Optional checksum byte is controlled by the DUMPER_CHECKSUM_EN macro (see memory_dumper.sv).
package memory_dumper_pkg;

  localparam int DEF_UART_DATA_LENGTH     = 8;
  localparam int DEF_REGISTER_WIDTH       = 4;
  localparam int DEF_MEMORY_ADDRESS_WIDTH = 4;

  typedef enum logic [2:0] {
    stIDLE = 3'd0,
    stRD_HI = 3'd1,
    stRD_LO = 3'd2,
    stCAPT = 3'd3,
    stSEND = 3'd4,
    stCHK = 3'd5,
    stDONE = 3'd6
  } dump_state_e;

endpackage

// File: rtl/memory_dumper_if.sv
// Memory read port, UART transmit handshake and dump control/status of the memory dumper.
// master = dumper side, slave = memory/transmitter/controller side.
interface memory_dumper_if
  import memory_dumper_pkg::*;
#(
  parameter int UART_DATA_LENGTH     = DEF_UART_DATA_LENGTH,
  parameter int REGISTER_WIDTH       = DEF_REGISTER_WIDTH,
  parameter int MEMORY_ADDRESS_WIDTH = DEF_MEMORY_ADDRESS_WIDTH
);

  logic                            start_strb_i;
  logic [REGISTER_WIDTH-1:0]       mem_data_i;
  logic                            tx_ready_i;
  logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o;
  logic                            mem_read_en_o;
  logic [UART_DATA_LENGTH-1:0]     tx_data_o;
  logic                            tx_valid_o;
  logic                            busy_o;
  logic                            done_strb_o;

  modport master (
    input  start_strb_i, mem_data_i, tx_ready_i,
    output mem_addr_o, mem_read_en_o, tx_data_o, tx_valid_o, busy_o, done_strb_o
  );

  modport slave (
    output start_strb_i, mem_data_i, tx_ready_i,
    input  mem_addr_o, mem_read_en_o, tx_data_o, tx_valid_o, busy_o, done_strb_o
  );

endinterface

// File: rtl/memory_dumper_dump_checksum.sv
// dump_checksum: wrapping accumulator of transmitted data bytes, cleared at the end of a dump.
module dump_checksum #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_add,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_sum
);

  logic [W-1:0] r_sum;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/memory_dumper.sv
// memory_dumper: reads the nibble memory from address 0, packs even/odd nibble pairs into bytes
// and streams them to the UART transmitter. DUMPER_CHECKSUM_EN appends a modulo-256 checksum byte.
module memory_dumper
  import memory_dumper_pkg::*;
#(
  parameter int UART_DATA_LENGTH     = DEF_UART_DATA_LENGTH,
  parameter int REGISTER_WIDTH       = DEF_REGISTER_WIDTH,
  parameter int MEMORY_ADDRESS_WIDTH = DEF_MEMORY_ADDRESS_WIDTH
) (
  input logic             clk_i,
  input logic             reset_ni,
  memory_dumper_if.master bus
);

  localparam int AW = MEMORY_ADDRESS_WIDTH;

  dump_state_e                 r_state;
  logic [AW:0]                 r_addr;
  logic [REGISTER_WIDTH-1:0]   r_hi;
  logic [AW-1:0]               r_mem_addr;
  logic                        r_rd_en;
  logic [UART_DATA_LENGTH-1:0] r_tx_data;
  logic                        r_tx_valid;
  logic                        r_busy;
  logic                        r_done;

  logic [AW:0]                 w_addr_inc;
  logic [UART_DATA_LENGTH-1:0] w_byte;

  assign w_addr_inc = r_addr + {{AW{1'b0}}, 1'b1};
  // Even address in the high nibble, matching the programming path.
  assign w_byte     = {r_hi, bus.mem_data_i};

`ifdef DUMPER_CHECKSUM_EN
  logic [UART_DATA_LENGTH-1:0] w_sum;
  logic                        w_chk_clear;
  logic                        w_chk_add;

  assign w_chk_clear = (r_state == stDONE);
  assign w_chk_add   = (r_state == stCAPT);

  dump_checksum #(
    .W(UART_DATA_LENGTH)
  ) u_dump_checksum (
    .i_clk  (clk_i),
    .i_rst_n(reset_ni),
    .i_clear(w_chk_clear),
    .i_add  (w_chk_add),
    .i_data (w_byte),
    .o_sum  (w_sum)
  );
`endif

  // Outputs are registered: each transition loads the values the next state presents.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state    <= stIDLE;
      r_addr     <= '0;
      r_hi       <= '0;
      r_mem_addr <= '0;
      r_rd_en    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        stIDLE: begin
          if (bus.start_strb_i) begin
            r_state    <= stRD_HI;
            r_busy     <= 1'b1;
            r_rd_en    <= 1'b1;
            r_mem_addr <= r_addr[AW-1:0];
          end
        end
        stRD_HI: begin
          r_addr     <= w_addr_inc;
          r_mem_addr <= w_addr_inc[AW-1:0];
          r_state    <= stRD_LO;
        end
        stRD_LO: begin
          r_hi       <= bus.mem_data_i;
          r_addr     <= w_addr_inc;
          r_rd_en    <= 1'b0;
          r_mem_addr <= '0;
          r_state    <= stCAPT;
        end
        stCAPT: begin
          r_tx_data  <= w_byte;
          r_tx_valid <= 1'b1;
          r_state    <= stSEND;
        end
        stSEND: begin
          if (bus.tx_ready_i) begin
            r_tx_valid <= 1'b0;
            if (!r_addr[AW]) begin
              r_state    <= stRD_HI;
              r_rd_en    <= 1'b1;
              r_mem_addr <= r_addr[AW-1:0];
            end else begin
`ifdef DUMPER_CHECKSUM_EN
              r_tx_data  <= w_sum;
              r_tx_valid <= 1'b1;
              r_state    <= stCHK;
`else
              r_done     <= 1'b1;
              r_state    <= stDONE;
`endif
            end
          end
        end
`ifdef DUMPER_CHECKSUM_EN
        stCHK: begin
          if (bus.tx_ready_i) begin
            r_tx_valid <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= stDONE;
          end
        end
`endif
        stDONE: begin
          r_addr  <= '0;
          r_busy  <= 1'b0;
          r_state <= stIDLE;
        end
        default: begin
          r_state <= stIDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr_o    = r_mem_addr;
  assign bus.mem_read_en_o = r_rd_en;
  assign bus.tx_data_o     = r_tx_data;
  assign bus.tx_valid_o    = r_tx_valid;
  assign bus.busy_o        = r_busy;
  assign bus.done_strb_o   = r_done;

endmodule

// File: tb/tb_memory_dumper.sv
// Bench for memory_dumper: 1-cycle-latency memory model, byte sequence predicted from memory contents.
module tb_memory_dumper;

  localparam int NB = 8;
`ifdef DUMPER_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  memory_dumper_if #(.UART_DATA_LENGTH(8), .REGISTER_WIDTH(4), .MEMORY_ADDRESS_WIDTH(4)) bus ();

  memory_dumper #(
    .UART_DATA_LENGTH(8),
    .REGISTER_WIDTH(4),
    .MEMORY_ADDRESS_WIDTH(4)
  ) dut (
    .clk_i   (clk),
    .reset_ni(rst_n),
    .bus     (bus.master)
  );

  logic [3:0] mem [16];
  int n_cmp = 0;
  int n_fail = 0;
  int ecnt = 0;
  int t0 = 0;
  logic [7:0] got_q[$];
  int dones = 0;
  int done_cyc = -1;
  logic prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b0;
  logic [7:0] prev_d = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory with fixed one-cycle read latency.
  always @(posedge clk) begin
    ecnt++;
    if (bus.mem_read_en_o) bus.mem_data_i <= mem[bus.mem_addr_o];
  end

  // Mid-cycle monitor: handshakes, done pulses, hold-while-stalled behaviour.
  always @(negedge clk) begin
    if (prev_rst && prev_v && !prev_r) begin
      check("hold_valid", {31'b0, bus.tx_valid_o}, 32'd1);
      check("hold_data", {24'b0, bus.tx_data_o}, {24'b0, prev_d});
      check("hold_noread", {31'b0, bus.mem_read_en_o}, 32'd0);
    end
    if (rst_n && bus.tx_valid_o && bus.tx_ready_i) got_q.push_back(bus.tx_data_o);
    if (bus.done_strb_o) begin
      dones++;
      done_cyc = ecnt - t0;
    end
    prev_v   = bus.tx_valid_o;
    prev_r   = bus.tx_ready_i;
    prev_d   = bus.tx_data_o;
    prev_rst = rst_n;
  end

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_addr"}, {28'b0, bus.mem_addr_o}, 32'd0);
    check({pfx, "_rden"}, {31'b0, bus.mem_read_en_o}, 32'd0);
    check({pfx, "_txdata"}, {24'b0, bus.tx_data_o}, 32'd0);
    check({pfx, "_txvalid"}, {31'b0, bus.tx_valid_o}, 32'd0);
    check({pfx, "_busy"}, {31'b0, bus.busy_o}, 32'd0);
    check({pfx, "_done"}, {31'b0, bus.done_strb_o}, 32'd0);
  endtask

  task automatic start_pulse();
    @(posedge clk); #1;
    bus.start_strb_i = 1'b1;
    bus.tx_ready_i   = 1'b1;
    t0 = ecnt;
    @(posedge clk); #1;
    bus.start_strb_i = 1'b0;
  endtask

  task automatic run_dump(input string name, input int stall_idx, input int stall_len,
                          input int restart_idx, input bit rand_ready, input bit check_time);
    logic [7:0] exp_q[$];
    logic [7:0] sum;
    int guard;
    int stall_left;
    bit stalled;
    bit restarted;
    sum = 8'h00;
    guard = 0;
    stall_left = 0;
    stalled = 1'b0;
    restarted = 1'b0;
    for (int i = 0; i < NB; i++) begin
      exp_q.push_back({mem[2*i], mem[2*i+1]});
      sum = sum + {mem[2*i], mem[2*i+1]};
    end
    if (CHK == 1) exp_q.push_back(sum);
    got_q.delete();
    dones = 0;
    done_cyc = -1;
    start_pulse();
    while (dones == 0 && guard < 4000) begin
      bus.start_strb_i = 1'b0;
      if (stall_left > 0) begin
        stall_left--;
        bus.tx_ready_i = (stall_left == 0);
      end else if (!stalled && stall_idx >= 0 && bus.tx_valid_o && got_q.size() == stall_idx) begin
        stalled = 1'b1;
        stall_left = stall_len;
        bus.tx_ready_i = 1'b0;
      end else if (rand_ready) begin
        bus.tx_ready_i = 1'($urandom_range(0, 1));
      end else begin
        bus.tx_ready_i = 1'b1;
      end
      if (!restarted && restart_idx >= 0 && bus.tx_valid_o && got_q.size() == restart_idx) begin
        restarted = 1'b1;
        bus.start_strb_i = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.start_strb_i = 1'b0;
    bus.tx_ready_i   = 1'b1;
    check({name, "_done_seen"}, dones, 32'd1);
    check({name, "_busy_after_done"}, {31'b0, bus.busy_o}, 32'd0);
    if (check_time) check({name, "_done_cycle"}, done_cyc, 4*NB + 1 + CHK + stall_len);
    repeat (6) @(posedge clk);
    #1;
    check({name, "_single_done"}, dones, 32'd1);
    check({name, "_byte_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i),
            (i < got_q.size()) ? {24'b0, got_q[i]} : 32'hxxxxxxxx, {24'b0, exp_q[i]});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.start_strb_i = 1'b0;
    bus.tx_ready_i   = 1'b1;
    bus.mem_data_i   = 4'h0;
    for (int a = 0; a < 16; a++) mem[a] = 4'(a);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    run_dump("ramp", -1, 0, -1, 1'b0, 1'b1);
    check("ramp_first", {24'b0, (got_q.size() > 0) ? got_q[0] : 8'hxx}, 32'h01);
    run_dump("stall", 1, 5, -1, 1'b0, 1'b1);
    run_dump("restart", -1, 0, 3, 1'b0, 1'b1);

    // Abort in SEND of byte 4 with ready low, then reset for one edge.
    got_q.delete();
    dones = 0;
    start_pulse();
    guard = 0;
    while (!(bus.tx_valid_o && got_q.size() == 4) && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    check("abort_reached_send4", {31'b0, bus.tx_valid_o}, 32'd1);
    bus.tx_ready_i = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_outputs_zero("abort");
    rst_n = 1'b1;
    bus.tx_ready_i = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", dones, 32'd0);
    check("abort_idle", {31'b0, bus.busy_o}, 32'd0);
    run_dump("after_abort", -1, 0, -1, 1'b0, 1'b1);

    for (int a = 0; a < 16; a++) mem[a] = 4'hF;
    run_dump("all_f", -1, 0, -1, 1'b0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < 16; a++) mem[a] = 4'($urandom_range(0, 15));
      run_dump($sformatf("rand%0d", r), -1, 0, -1, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_dumper.md
# memory_dumper

Read-back counterpart to the UART programming path. On a start strobe it reads the whole nibble-wide program memory in address order, starting at address 0. It packs each pair of consecutive nibbles into one byte and hands the bytes to the UART transmitter over a valid/ready handshake. Nibble order matches the programming path: the even address goes in the high nibble and the odd address in the low nibble, so a dumped image can be re-sent byte-for-byte to reprogram the memory.

## Interface
Parameters:
- UART_DATA_LENGTH, 8, transmitted byte width; must equal 2*REGISTER_WIDTH.
- REGISTER_WIDTH, 4, memory word (nibble) width.
- MEMORY_ADDRESS_WIDTH, 4, memory address width; depth 2^MEMORY_ADDRESS_WIDTH words, must be even.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- reset_ni  in  1  synchronous, active-low reset.
- start_strb_i  in  1  one-cycle request to begin a dump.
- mem_data_i  in  REGISTER_WIDTH  memory read data, valid one cycle after mem_read_en_o.
- tx_ready_i  in  1  transmitter accepts tx_data_o this cycle.
- mem_addr_o  out  MEMORY_ADDRESS_WIDTH  read address.
- mem_read_en_o  out  1  read request.
- tx_data_o  out  UART_DATA_LENGTH  byte to send.
- tx_valid_o  out  1  tx_data_o is valid.
- busy_o  out  1  dump in progress.
- done_strb_o  out  1  one-cycle pulse at end of dump.

## Operation
- The address counter is MEMORY_ADDRESS_WIDTH+1 bits. Its MSB set means the last word has been read.
- States:
  - IDLE: waits for start_strb_i, then goes to RD_HI.
  - RD_HI: mem_addr_o=addr, mem_read_en_o=1; addr++; goes to RD_LO.
  - RD_LO: latches mem_data_i into hi; mem_addr_o=addr, mem_read_en_o=1; addr++; goes to CAPT.
  - CAPT: byte={hi, mem_data_i}; checksum+=byte; goes to SEND.
  - SEND: tx_valid_o=1 until tx_ready_i. On handshake: goes to RD_HI if the counter MSB is 0. Otherwise goes to CHK (macro defined) or DONE (macro undefined).
  - CHK: tx_data_o=checksum, tx_valid_o=1 until tx_ready_i; then goes to DONE.
  - DONE: done_strb_o=1; goes to IDLE. Counter and checksum cleared.
- busy_o=1 in every state except IDLE.
- start_strb_i is ignored unless in IDLE.
- tx_ready_i is ignored outside SEND and CHK.
- Outside RD_HI and RD_LO: mem_addr_o=0, mem_read_en_o=0.
- Checksum is an UART_DATA_LENGTH-bit sum that wraps modulo 2^UART_DATA_LENGTH.

## Timing
- Reset (reset_ni=0 at a rising edge) forces IDLE. All outputs are 0 in the following cycle; counter, hi and checksum are cleared.
- Reset mid-dump aborts the dump immediately, with no done_strb_o. A later start restarts from address 0.
- With start sampled at edge 0, states run RD_HI in cycle 1, RD_LO in cycle 2, CAPT in cycle 3, and tx_valid_o rises in cycle 4.
- With tx_ready_i held at 1, each byte takes 4 cycles.
- While tx_valid_o=1 and tx_ready_i=0, tx_data_o stays stable and tx_valid_o stays asserted. There is no retraction.
- Memory read latency is fixed at 1 cycle; mem_data_i is sampled exactly one cycle after mem_read_en_o.

## Configuration
- DUMPER_CHECKSUM_EN defined: a final byte is sent after the data bytes, equal to the modulo-256 sum of all data bytes. Total 2^(MEMORY_ADDRESS_WIDTH-1)+1 bytes.
- DUMPER_CHECKSUM_EN undefined: the CHK state and the checksum register are absent. SEND goes directly to DONE after the last byte, for 2^(MEMORY_ADDRESS_WIDTH-1) bytes.

## Structure
- The shared CPU package holds:
  - default width constants (UART_DATA_LENGTH, REGISTER_WIDTH, MEMORY_ADDRESS_WIDTH);
  - the dumper state encoding stIDLE..stDONE, 3 bits.
- One sub-module, dump_checksum: accumulator with clear/add inputs, instantiated only under DUMPER_CHECKSUM_EN.

## Test plan
- Memory holds value=address (0..F), tx_ready_i=1, macro undefined, start at edge 0:
  - required bytes in order: 0x01, 0x23, 0x45, 0x67, 0x89, 0xAB, 0xCD, 0xEF;
  - done_strb_o pulses in cycle 33; busy_o then falls.
- Same memory, macro defined: the 9th byte is 0xC0; done_strb_o pulses in cycle 34.
- tx_ready_i held 0 for 5 cycles while byte 0x23 is valid: tx_valid_o stays 1, tx_data_o stays 0x23, and no memory reads occur. The dump completes normally after ready returns.
- start_strb_i pulsed during byte 3: no restart; the byte sequence is unchanged and only one done_strb_o is seen.
- reset_ni=0 for one edge while in SEND of byte 4:
  - next cycle: all outputs 0;
  - a subsequent start yields 0x01 first, with the checksum recomputed from zero.
- Memory filled with 0xF: every byte is 0xFF; with the macro defined, the checksum is 0xF8 (8*0xFF mod 256), exercising wrap-around.
